// File: rtl/ysyx_bus_ifu_rsp_pkg.sv
// rtl/ysyx_bus_ifu_rsp_pkg.sv - shared types and AXI constants for the IFU fetch responder
package ysyx_bus_ifu_rsp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_DROP = 2'd3
   } ysyx_ifu_rsp_state_t;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;

endpackage

// File: rtl/ysyx_bus_ifu_rsp.sv
// rtl/ysyx_bus_ifu_rsp.sv - IFU fetch port to single-beat AXI4 read, one transaction outstanding
// Optional one-entry hit buffer enabled by YSYX_IFU_RSP_HITBUF_EN.
module ysyx_bus_ifu_rsp
   import ysyx_bus_ifu_rsp_pkg::*;
#(
   parameter int         XLEN   = 32,
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] ifu_araddr,
   input  logic            ifu_arvalid,
   input  logic            ifu_lock,
   output logic            bus_ifu_ready,
   output logic [XLEN-1:0] ifu_rdata,
   output logic            ifu_rvalid,
   output logic            ifu_rerr,
   input  logic            flush_pipeline,
   input  logic            fence_i,
   output logic            bus_lock,
   output logic            axi_arvalid,
   input  logic            axi_arready,
   output logic [XLEN-1:0] axi_araddr,
   output logic [3:0]      axi_arid,
   output logic [7:0]      axi_arlen,
   output logic [2:0]      axi_arsize,
   output logic [1:0]      axi_arburst,
   input  logic            axi_rvalid,
   output logic            axi_rready,
   input  logic            axi_rlast,
   input  logic [XLEN-1:0] axi_rdata,
   input  logic [1:0]      axi_rresp,
   input  logic [3:0]      axi_rid
);

   ysyx_ifu_rsp_state_t state_q, state_d;
   logic [XLEN-1:0]     addr_q;
   logic [XLEN-1:0]     rdata_q;
   logic                rvalid_q;
   logic                rerr_q;
   logic                accept;
   logic                hit;
   logic [XLEN-1:0]     hit_data;
   logic                beat_ok;
   logic                unused_ok;

   assign accept  = ifu_arvalid && (state_q == ST_IDLE);
   assign beat_ok = (state_q == ST_R) && axi_rvalid && !flush_pipeline;

`ifdef YSYX_IFU_RSP_HITBUF_EN
   logic            hb_valid_q;
   logic [XLEN-3:0] hb_tag_q;
   logic [XLEN-1:0] hb_data_q;

   // fence_i invalidates before lookup, so a same-cycle request misses
   assign hit      = hb_valid_q && !fence_i && (hb_tag_q == ifu_araddr[XLEN-1:2]);
   assign hit_data = hb_data_q;

   always_ff @(posedge clock) begin
      if (reset || fence_i) begin
         hb_valid_q <= 1'b0;
      end else if (beat_ok && (axi_rresp == RESP_OKAY)) begin
         hb_valid_q <= 1'b1;
         hb_tag_q   <= addr_q[XLEN-1:2];
         hb_data_q  <= axi_rdata;
      end
   end

   assign unused_ok = ^{axi_rlast, axi_rid, ifu_araddr[1:0]};
`else
   assign hit       = 1'b0;
   assign hit_data  = '0;
   assign unused_ok = ^{axi_rlast, axi_rid, ifu_araddr[1:0], fence_i};
`endif

   always_comb begin
      state_d     = state_q;
      axi_arvalid = 1'b0;
      axi_rready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && !hit) state_d = ST_AR;
         end
         ST_AR: begin
            axi_arvalid = 1'b1;
            if (axi_arready) state_d = flush_pipeline ? ST_DROP : ST_R;
         end
         ST_R: begin
            axi_rready = 1'b1;
            // a flush with no beat yet must still swallow the outstanding beat
            if (flush_pipeline)  state_d = axi_rvalid ? ST_IDLE : ST_DROP;
            else if (axi_rvalid) state_d = ST_IDLE;
         end
         ST_DROP: begin
            axi_rready = 1'b1;
            if (axi_rvalid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= 1'b0;
         if (accept) addr_q <= {ifu_araddr[XLEN-1:2], 2'b00};
         if (beat_ok) begin
            rvalid_q <= 1'b1;
            rdata_q  <= axi_rdata;
            rerr_q   <= (axi_rresp != RESP_OKAY);
         end else if (accept && hit) begin
            rvalid_q <= 1'b1;
            rdata_q  <= hit_data;
            rerr_q   <= 1'b0;
         end
      end
   end

   assign bus_ifu_ready = (state_q == ST_IDLE);
   assign ifu_rvalid    = rvalid_q;
   assign ifu_rdata     = rdata_q;
   assign ifu_rerr      = rvalid_q && rerr_q;
   assign bus_lock      = ifu_lock || (state_q != ST_IDLE);
   assign axi_araddr    = addr_q;
   assign axi_arid      = AXI_ID;
   assign axi_arlen     = 8'd0;
   assign axi_arsize    = SIZE_4B;
   assign axi_arburst   = BURST_INCR;

endmodule

// File: tb/tb_ysyx_bus_ifu_rsp.sv
// tb/tb_ysyx_bus_ifu_rsp.sv - randomized self-checking bench for the IFU fetch responder
module tb_ysyx_bus_ifu_rsp;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] ifu_araddr;
   logic        ifu_arvalid, ifu_lock, bus_ifu_ready;
   logic [31:0] ifu_rdata;
   logic        ifu_rvalid, ifu_rerr, flush_pipeline, fence_i, bus_lock;
   logic        axi_arvalid, axi_arready;
   logic [31:0] axi_araddr;
   logic [3:0]  axi_arid;
   logic [7:0]  axi_arlen;
   logic [2:0]  axi_arsize;
   logic [1:0]  axi_arburst;
   logic        axi_rvalid, axi_rready, axi_rlast;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic [3:0]  axi_rid;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef YSYX_IFU_RSP_HITBUF_EN
   bit          hb_valid = 0;
   logic [29:0] hb_tag;
   logic [31:0] hb_data;
`endif

   ysyx_bus_ifu_rsp dut (
      .clock(clock), .reset(reset),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_lock(ifu_lock),
      .bus_ifu_ready(bus_ifu_ready), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
      .ifu_rerr(ifu_rerr), .flush_pipeline(flush_pipeline), .fence_i(fence_i),
      .bus_lock(bus_lock), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen),
      .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_rvalid(axi_rvalid),
      .axi_rready(axi_rready), .axi_rlast(axi_rlast), .axi_rdata(axi_rdata),
      .axi_rresp(axi_rresp), .axi_rid(axi_rid)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One IFU request; the bench plays the AXI slave with the given delays and beat.
   // flush_at: R-phase cycle index at which flush_pipeline pulses, -1 for none.
   task automatic fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                        input logic [31:0] data, input logic [1:0] resp,
                        input int flush_at, input bit flush_acc);
      bit          hit;
      logic [31:0] hdata;
      hit   = 0;
      hdata = '0;
`ifdef YSYX_IFU_RSP_HITBUF_EN
      hit   = hb_valid && (hb_tag == addr[31:2]);
      hdata = hb_data;
`endif
      check("accept_ready", {31'd0, bus_ifu_ready}, 32'd1);
      ifu_araddr     = addr;
      ifu_arvalid    = 1'b1;
      flush_pipeline = flush_acc;
      step();
      ifu_arvalid    = 1'b0;
      flush_pipeline = 1'b0;
      ifu_araddr     = $urandom;
      if (hit) begin
         check("hit_no_arvalid", {31'd0, axi_arvalid}, 32'd0);
         check("hit_rvalid", {31'd0, ifu_rvalid}, 32'd1);
         check("hit_rdata", ifu_rdata, hdata);
         check("hit_rerr", {31'd0, ifu_rerr}, 32'd0);
         return;
      end
      check("pulse_end", {31'd0, ifu_rvalid}, 32'd0);
      for (int i = 0; i <= ar_wait; i++) begin
         check("ar_valid", {31'd0, axi_arvalid}, 32'd1);
         check("ar_addr", axi_araddr, {addr[31:2], 2'b00});
         check("ar_busy", {31'd0, bus_ifu_ready}, 32'd0);
         check("ar_lock", {31'd0, bus_lock}, 32'd1);
         if (i == 0)
            check("ar_fields", {axi_arid, axi_arlen, axi_arsize, axi_arburst},
                  {4'd0, 8'd0, 3'b010, 2'b01});
         axi_arready = (i == ar_wait);
         step();
      end
      axi_arready = 1'b0;
      for (int i = 0; i <= r_wait; i++) begin
         check("r_ready", {31'd0, axi_rready}, 32'd1);
         check("r_no_pulse", {31'd0, ifu_rvalid}, 32'd0);
         check("r_busy", {31'd0, bus_ifu_ready}, 32'd0);
         axi_rvalid     = (i == r_wait);
         axi_rdata      = (i == r_wait) ? data : $urandom;
         axi_rresp      = resp;
         axi_rid        = 4'($urandom);
         axi_rlast      = 1'b1;
         flush_pipeline = (i == flush_at);
         step();
      end
      axi_rvalid     = 1'b0;
      flush_pipeline = 1'b0;
      if (flush_at >= 0) begin
         check("drop_no_rvalid", {31'd0, ifu_rvalid}, 32'd0);
         check("drop_ready", {31'd0, bus_ifu_ready}, 32'd1);
      end else begin
         check("rsp_rvalid", {31'd0, ifu_rvalid}, 32'd1);
         check("rsp_rdata", ifu_rdata, data);
         check("rsp_rerr", {31'd0, ifu_rerr}, {31'd0, resp != 2'b00});
         check("rsp_ready", {31'd0, bus_ifu_ready}, 32'd1);
`ifdef YSYX_IFU_RSP_HITBUF_EN
         if (resp == 2'b00) begin
            hb_valid = 1;
            hb_tag   = addr[31:2];
            hb_data  = data;
         end
`endif
      end
   endtask

   task automatic fence();
      fence_i = 1'b1;
      step();
      fence_i = 1'b0;
`ifdef YSYX_IFU_RSP_HITBUF_EN
      hb_valid = 0;
`endif
   endtask

   initial begin
      reset = 1'b1;
      ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_lock = 1'b0;
      flush_pipeline = 1'b0; fence_i = 1'b0;
      axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
      axi_rdata = '0; axi_rresp = '0; axi_rid = '0;
      step(); step();
      reset = 1'b0;

      check("rst_ready", {31'd0, bus_ifu_ready}, 32'd1);
      check("rst_rvalid", {31'd0, ifu_rvalid}, 32'd0);
      check("rst_rerr", {31'd0, ifu_rerr}, 32'd0);
      check("rst_rdata", ifu_rdata, 32'd0);
      check("rst_arvalid", {31'd0, axi_arvalid}, 32'd0);
      check("rst_rready", {31'd0, axi_rready}, 32'd0);
      check("rst_lock", {31'd0, bus_lock}, 32'd0);
      ifu_lock = 1'b1;
      #1 check("lock_idle", {31'd0, bus_lock}, 32'd1);
      ifu_lock = 1'b0;

      fetch(32'h8000_0000, 0, 0, 32'h0000_0413, 2'b00, -1, 0);
      fetch(32'h8000_0107, 5, 1, 32'h1234_5678, 2'b00, -1, 0);
      fetch(32'h8000_0200, 0, 2, 32'hdead_beef, 2'b00, 0, 0);
      fetch(32'h8000_0300, 1, 0, 32'h0bad_0bad, 2'b10, -1, 1);
      step();
      check("err_pulse_end", {31'd0, ifu_rvalid}, 32'd0);
      check("err_rerr_end", {31'd0, ifu_rerr}, 32'd0);

      fetch(32'h8000_0010, 0, 0, 32'h0000_0093, 2'b00, -1, 0);
      fetch(32'h8000_0010, 2, 1, 32'h0000_0093, 2'b00, -1, 0);
      fence();
      fetch(32'h8000_0010, 0, 0, 32'h0000_0113, 2'b00, -1, 0);

      ifu_araddr  = 32'h8000_0400;
      ifu_arvalid = 1'b1;
      step();
      ifu_arvalid = 1'b0;
      check("rstar_arvalid_pre", {31'd0, axi_arvalid}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
`ifdef YSYX_IFU_RSP_HITBUF_EN
      hb_valid = 0;
`endif
      check("rstar_arvalid", {31'd0, axi_arvalid}, 32'd0);
      check("rstar_ready", {31'd0, bus_ifu_ready}, 32'd1);
      check("rstar_rvalid", {31'd0, ifu_rvalid}, 32'd0);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         int          rw, fa;
         logic [1:0]  rs;
         a  = 32'h8000_0000 | {25'd0, 3'($urandom_range(0, 7)), 4'($urandom)};
         rw = $urandom_range(0, 3);
         fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rw) : -1;
         rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if ($urandom_range(0, 9) == 0) fence();
         if ($urandom_range(0, 2) == 0) step();
         fetch(a, $urandom_range(0, 3), rw, $urandom, rs, fa, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
